// File: rtl/sid_write_sequencer.sv
// Timed command sequencer: replays FIFO'd {wait, reg, value} commands as single-cycle
// writes into the SID register window. Optional shadow readback under `SID_SHADOW_EN.
module sid_write_sequencer #(
   parameter int         FIFO_AW  = 4,
   parameter int         TICK_DIV = 50000,
   parameter logic [9:0] SID_BASE = 10'h150
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             flush,
   input  logic             cmd_push,
   input  logic [23:0]      cmd_data,
   output logic             cmd_full,
   output logic [FIFO_AW:0] cmd_level,
   input  logic             bus_busy,
   output logic             mem_wr,
   output logic [14:0]      mem_w_addr,
   output logic [7:0]       mem_data_wr,
   output logic [1:0]       err_sticky
`ifdef SID_SHADOW_EN
   ,
   input  logic [4:0]       shadow_addr,
   output logic [7:0]       shadow_data
`endif
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, ISSUE} state_t;

   state_t             state;
   logic [PW-1:0]      presc;
   logic               tick;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [20:0]        fifo_mem [DEPTH];
   logic [20:0]        fifo_q_p0;
   logic [12:0]        cmd_q_p1;
   logic [7:0]         cnt;
   logic               wr_p0;
   logic               push_ok;
   logic               pop;
   logic               rsvd_unused;

   // Reserved command bits carry no meaning and are not stored.
   assign rsvd_unused = ^cmd_data[15:13];

   assign tick     = (presc == PRESC_MAX);
   assign cmd_full = cmd_level[FIFO_AW];
   // No pop while a strobe is pending, which keeps writes at least 4 cycles apart.
   assign pop      = (state == IDLE) && enable && (cmd_level != '0) && !wr_p0 && !flush;
   assign push_ok  = cmd_push && !flush && (!cmd_full || pop);

   // Stage p0: FIFO storage with registered read
   always_ff @(posedge vga_clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= {cmd_data[23:16], cmd_data[12:0]};
      if (pop)
         fifo_q_p0 <= fifo_mem[rd_ptr];
   end

   // Stage p1: command held for the write stage
   always_ff @(posedge vga_clk) begin
      if (state == LOAD)
         cmd_q_p1 <= fifo_q_p0[12:0];
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state       <= IDLE;
         presc       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cmd_level   <= '0;
         cnt         <= '0;
         wr_p0       <= 1'b0;
         err_sticky  <= 2'b00;
         mem_wr      <= 1'b0;
         mem_w_addr  <= '0;
         mem_data_wr <= '0;
      end else begin
         presc  <= tick ? '0 : presc + 1'b1;
         mem_wr <= 1'b0;
         if (flush) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cmd_level  <= '0;
            wr_p0      <= 1'b0;
            err_sticky <= 2'b00;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
               2'b10:   cmd_level <= cmd_level + 1'b1;
               2'b01:   cmd_level <= cmd_level - 1'b1;
               default: ;
            endcase
            if (cmd_push && cmd_full && !pop)
               err_sticky[0] <= 1'b1;

            wr_p0 <= 1'b0;
            if (wr_p0) begin
               mem_wr      <= 1'b1;
               mem_w_addr  <= {SID_BASE, cmd_q_p1[12:8]};
               mem_data_wr <= cmd_q_p1[7:0];
            end

            case (state)
               IDLE: if (pop) state <= LOAD;
               LOAD: begin
                  cnt   <= fifo_q_p0[20:13];
                  state <= (fifo_q_p0[20:13] == 8'd0) ? ISSUE : WAIT;
               end
               WAIT: if (tick) begin
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1)
                     state <= ISSUE;
               end
               ISSUE: if (!bus_busy) begin
                  if (cmd_q_p1[12:8] > 5'd24)
                     err_sticky[1] <= 1'b1;
                  else
                     wr_p0 <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SID_SHADOW_EN
   logic [7:0] shadow [25];

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int i = 0; i < 25; i++)
            shadow[i] <= 8'h00;
         shadow_data <= 8'h00;
      end else begin
         if (wr_p0 && !flush)
            shadow[cmd_q_p1[12:8]] <= cmd_q_p1[7:0];
         shadow_data <= (shadow_addr <= 5'd24) ? shadow[shadow_addr] : 8'h00;
      end
   end
`endif

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Scoreboard bench for sid_write_sequencer: stimulus queues expected writes, a negedge
// monitor pops and compares every strobe. TICK_DIV is shortened to 8.
module tb_sid_write_sequencer;

   localparam int TD = 8;

   logic        vga_clk = 1'b0;
   logic        reset, enable, flush, cmd_push, bus_busy;
   logic [23:0] cmd_data;
   logic        cmd_full;
   logic [4:0]  cmd_level;
   logic        mem_wr;
   logic [14:0] mem_w_addr;
   logic [7:0]  mem_data_wr;
   logic [1:0]  err_sticky;
`ifdef SID_SHADOW_EN
   logic [4:0]  shadow_addr;
   logic [7:0]  shadow_data;
`endif

   sid_write_sequencer #(.FIFO_AW(4), .TICK_DIV(TD), .SID_BASE(10'h150)) dut (
      .vga_clk(vga_clk), .reset(reset), .enable(enable), .flush(flush),
      .cmd_push(cmd_push), .cmd_data(cmd_data), .cmd_full(cmd_full),
      .cmd_level(cmd_level), .bus_busy(bus_busy), .mem_wr(mem_wr),
      .mem_w_addr(mem_w_addr), .mem_data_wr(mem_data_wr), .err_sticky(err_sticky)
`ifdef SID_SHADOW_EN
      , .shadow_addr(shadow_addr), .shadow_data(shadow_data)
`endif
   );

   always #5 vga_clk = ~vga_clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          strobe_cnt = 0;
   int          last_strobe = 0;
   logic [22:0] exp_q [$];

   always @(posedge vga_clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest queued expectation
   always @(negedge vga_clk) begin
      if (!reset && mem_wr) begin
         logic [22:0] e;
         strobe_cnt++;
         last_strobe = cyc;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected: got addr %0h data %0h expected no strobe", mem_w_addr, mem_data_wr);
         end else begin
            e = exp_q.pop_front();
            check("sb_addr", {17'd0, mem_w_addr}, {17'd0, e[22:8]});
            check("sb_data", {24'd0, mem_data_wr}, {24'd0, e[7:0]});
         end
      end
   end

   task automatic push(input logic [23:0] d, input bit expect_wr, output int p);
      cmd_data = d;
      cmd_push = 1'b1;
      if (expect_wr) exp_q.push_back({10'h150, d[12:8], d[7:0]});
      @(posedge vga_clk);
      #1;
      cmd_push = 1'b0;
      p = cyc;
   endtask

   task automatic wait_strobe(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (strobe_cnt < target && k < budget) begin
         @(posedge vga_clk);
         #1;
         k++;
      end
      if (strobe_cnt < target) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: got %0d strobes expected %0d (timeout)", name, strobe_cnt, target);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge vga_clk);
      #1;
   endtask

   // First strobe cycle for a wait>0 command pushed at cycle p: ticks fall on cyc%TD==0,
   // the LOAD edge (p+2) does not count, strobe lands two edges after the final tick.
   function automatic int exp_time(input int p, input int w);
      int t1;
      t1 = ((p + 2) / TD + 1) * TD;
      return t1 + (w - 1) * TD + 2;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, s0, f;
      reset = 1'b1; enable = 1'b0; flush = 1'b0; cmd_push = 1'b0;
      bus_busy = 1'b0; cmd_data = '0;
`ifdef SID_SHADOW_EN
      shadow_addr = '0;
`endif
      cycles(3);
      check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      check("rst_addr", {17'd0, mem_w_addr}, 32'd0);
      check("rst_data", {24'd0, mem_data_wr}, 32'd0);
      check("rst_full", {31'd0, cmd_full}, 32'd0);
      check("rst_level", {27'd0, cmd_level}, 32'd0);
      check("rst_err", {30'd0, err_sticky}, 32'd0);
      reset = 1'b0;
      enable = 1'b1;
      cycles(2);

      // Latency: strobe exactly on the 4th edge after the push, for one cycle
      push(24'h00180F, 1'b1, p);
      for (int k = 1; k <= 5; k++) begin
         cycles(1);
         check($sformatf("t1_strobe_e%0d", k), {31'd0, mem_wr}, (k == 4) ? 32'd1 : 32'd0);
      end
      check("t1_addr_hold", {17'd0, mem_w_addr}, 32'h2A18);
      check("t1_data_hold", {24'd0, mem_data_wr}, 32'h0F);

      // Wait=3, pushed so that a tick coincides with the LOAD cycle
      for (int k = 0; k < TD && (cyc % TD) != TD - 3; k++) cycles(1);
      s0 = strobe_cnt;
      push({8'd3, 3'b000, 5'd4, 8'h41}, 1'b1, p);
      wait_strobe(s0 + 1, 60, "t2_wait");
      check("t2_time", last_strobe, exp_time(p, 3));
      check("t2_min_delay", {31'd0, (last_strobe - p) >= 17}, 32'd1);

      // Bus busy holds ISSUE off; one strobe two edges after release
      bus_busy = 1'b1;
      s0 = strobe_cnt;
      push({8'd0, 3'b000, 5'd2, 8'h55}, 1'b1, p);
      for (int k = 0; k < 10; k++) begin
         cycles(1);
         check("t4_busy_hold", {31'd0, mem_wr}, 32'd0);
      end
      bus_busy = 1'b0;
      cycles(1);
      check("t4_release_e1", {31'd0, mem_wr}, 32'd0);
      cycles(1);
      check("t4_release_e2", {31'd0, mem_wr}, 32'd1);
      cycles(1);
      check("t4_release_e3", {31'd0, mem_wr}, 32'd0);
      check("t4_count", strobe_cnt - s0, 32'd1);

      // Fill while paused, overflow, then push+pop in the same cycle while full
      enable = 1'b0;
      cycles(2);
      for (int i = 0; i < 17; i++)
         push({8'd0, 3'b000, 5'(i), 8'(8'h80 + i)}, i < 16, p);
      check("t3_full", {31'd0, cmd_full}, 32'd1);
      check("t3_level", {27'd0, cmd_level}, 32'd16);
      check("t3_err0", {30'd0, err_sticky}, 32'd1);
      s0 = strobe_cnt;
      enable = 1'b1;
      push({8'd0, 3'b000, 5'd17, 8'h91}, 1'b1, p);
      check("t3_level_pushpop", {27'd0, cmd_level}, 32'd16);
      wait_strobe(s0 + 1, 20, "t3_first");
      f = last_strobe;
      wait_strobe(s0 + 17, 120, "t3_all");
      check("t3_spacing", last_strobe - f, 32'd64);
      check("t3_level_empty", {27'd0, cmd_level}, 32'd0);

      // Flush clears the sticky errors
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      check("flush_err", {30'd0, err_sticky}, 32'd0);

      // Out-of-window register is dropped with an error
      s0 = strobe_cnt;
      push({8'd0, 3'b000, 5'd27, 8'h33}, 1'b0, p);
      cycles(8);
      check("t5_err1", {30'd0, err_sticky}, 32'd2);
      check("t5_nostrobe", strobe_cnt - s0, 32'd0);

      // Flush mid-WAIT with one more queued, and a push in the flush cycle
      push({8'd5, 3'b000, 5'd5, 8'h01}, 1'b0, p);
      push({8'd5, 3'b000, 5'd6, 8'h02}, 1'b0, p);
      cycles(12);
      check("t5_level_pre", {27'd0, cmd_level}, 32'd1);
      flush = 1'b1;
      cmd_push = 1'b1;
      cmd_data = {8'd0, 3'b000, 5'd7, 8'h03};
      cycles(1);
      flush = 1'b0;
      cmd_push = 1'b0;
      check("t5_flush_err", {30'd0, err_sticky}, 32'd0);
      check("t5_flush_level", {27'd0, cmd_level}, 32'd0);
      cycles(60);
      check("t5_flush_nostrobe", strobe_cnt - s0, 32'd0);

      // Maximum wait of 255 ticks
      s0 = strobe_cnt;
      push({8'd255, 3'b000, 5'd1, 8'hAA}, 1'b1, p);
      wait_strobe(s0 + 1, 2200, "t7_wait255");
      check("t7_time", last_strobe, exp_time(p, 255));

`ifdef SID_SHADOW_EN
      s0 = strobe_cnt;
      push({8'd0, 3'b000, 5'd24, 8'h1F}, 1'b1, p);
      wait_strobe(s0 + 1, 20, "t6_write");
      shadow_addr = 5'd24;
      cycles(1);
      check("t6_shadow", {24'd0, shadow_data}, 32'h1F);
      shadow_addr = 5'd30;
      cycles(1);
      check("t6_shadow_oob", {24'd0, shadow_data}, 32'h00);
`endif

      cycles(4);
      check("sb_drain", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
